// File: rtl/acorn128_pkg.sv
// Shared types and constants for the ACORN-128 byte-stream loader.
package acorn128_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    SEND   = 3'd4
  } state_e;

  localparam int ACORN_BLK_BYTES = 16;
  localparam int ACORN_FIELDS    = 4;
  localparam int ACORN_OUT_BYTES = 32;

  localparam int KEY = 0;
  localparam int IV  = 1;
  localparam int AD  = 2;
  localparam int TXT = 3;

  // Big-endian lane: byte position 0 lands in bits [127:120].
  function automatic logic [6:0] byte_lsb(input logic [3:0] pos);
    return {~pos, 3'b000};
  endfunction

endpackage

// File: rtl/acorn128_byte_serializer.sv
// 256-bit load/shift register that drains MSB-first as a byte stream,
// flagging the final byte with last_o.
module acorn128_byte_serializer
  import acorn128_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [255:0] data_i,
  input  logic         ready_i,
  output logic [7:0]   data_o,
  output logic         valid_o,
  output logic         last_o
);

  localparam logic [4:0] LAST_IDX = 5'(ACORN_OUT_BYTES - 1);

  logic [255:0] sreg_q, sreg_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic [4:0]   cnt_q, cnt_d;

  // Next-state for the shift register and byte counter.
  always_comb begin
    sreg_d  = sreg_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      sreg_d  = data_i;
      valid_d = 1'b1;
      last_d  = 1'b0;
      cnt_d   = 5'd0;
    end else if (valid_q && ready_i) begin
      sreg_d = {sreg_q[247:0], 8'h00};
      if (cnt_q == LAST_IDX) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        cnt_d   = 5'd0;
      end else begin
        cnt_d  = cnt_q + 5'd1;
        last_d = (cnt_q == (LAST_IDX - 5'd1));
      end
    end else begin
      sreg_d = sreg_q;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q  <= 256'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      sreg_q  <= sreg_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o  = sreg_q[255:248];
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/acorn128_stream_loader.sv
// Byte-stream front end for acorn128_top: frames in operands, returns result+tag.
// Optional ACORN_TAGCHK_EN: decrypt frames carry an expected tag checked on capture.
module acorn128_stream_loader
  import acorn128_pkg::*;
#(
  parameter  int DATA_LEN       = 128,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         encrypt_out,
  output logic         start_out,
  output logic [127:0] key_out,
  output logic [127:0] iv_out,
  output logic [127:0] ad_out,
  output logic [127:0] text_out,
  output logic [63:0]  data_length_out,
  input  logic         ready_in,
  input  logic [127:0] result_in,
  input  logic [127:0] tag_in,
  output logic [7:0]   m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         error_out
`ifdef ACORN_TAGCHK_EN
  ,
  output logic         tag_ok_out
`endif
);

  localparam logic [6:0] LOAD_LAST = 7'(ACORN_FIELDS * ACORN_BLK_BYTES - 1);

  state_e          state_q, state_d;
  logic [6:0]      bcnt_q, bcnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            enc_q, enc_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic            srdy_q, srdy_d;
  logic [127:0]    key_q, iv_q, ad_q, txt_q;

  logic            s_xfer_s;
  logic            hdr_s;
  logic            cap_s;
  logic            m_valid_s;
  logic            m_last_s;
  logic [2:0]      fld_s;
  logic [6:0]      lsb_s;
  logic [6:0]      last_idx_s;
  logic [255:0]    cap_data_s;

  assign s_xfer_s = s_valid & srdy_q;
  assign hdr_s    = (state_q == IDLE) & s_xfer_s;
  assign cap_s    = (state_q == WAIT) & ready_in;
  assign fld_s    = bcnt_q[6:4];
  assign lsb_s    = byte_lsb(bcnt_q[3:0]);

`ifdef ACORN_TAGCHK_EN
  logic [127:0] exp_q;
  logic         tag_ok_q;
  logic         tag_match_s;

  assign tag_match_s = (tag_in == exp_q);
  assign last_idx_s  = enc_q ? LOAD_LAST : (LOAD_LAST + 7'd16);
  // A failed decrypt check suppresses the plaintext but still returns the tag.
  assign cap_data_s  = {(enc_q | tag_match_s) ? result_in : 128'd0, tag_in};

  // Encrypt frames carry no expected tag, so they report ok.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_ok_q <= 1'b0;
    end else if (hdr_s) begin
      tag_ok_q <= 1'b0;
    end else if (cap_s) begin
      tag_ok_q <= enc_q | tag_match_s;
    end else begin
      tag_ok_q <= tag_ok_q;
    end
  end

  assign tag_ok_out = tag_ok_q;
`else
  assign last_idx_s = LOAD_LAST;
  assign cap_data_s = {result_in, tag_in};
`endif

  // Loader FSM next-state logic.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    to_d    = to_q;
    enc_d   = enc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (s_xfer_s) begin
          enc_d   = s_data[0];
          err_d   = 1'b0;
          bcnt_d  = 7'd0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (s_xfer_s) begin
          if (bcnt_q == last_idx_s) begin
            state_d = LAUNCH;
          end else begin
            bcnt_d = bcnt_q + 7'd1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      LAUNCH: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ready_in) begin
          state_d = SEND;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      SEND: begin
        if (m_valid_s && m_ready && m_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    srdy_d  = (state_d == IDLE) || (state_d == LOAD);
    start_d = (state_d == LAUNCH) || (state_d == WAIT);
  end

  // Loader FSM and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcnt_q  <= 7'd0;
      to_q    <= '0;
      enc_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      srdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      to_q    <= to_d;
      enc_q   <= enc_d;
      start_q <= start_d;
      err_q   <= err_d;
      srdy_q  <= srdy_d;
    end
  end

  // Operand byte steering; fields hold their value until overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q <= 128'd0;
      iv_q  <= 128'd0;
      ad_q  <= 128'd0;
      txt_q <= 128'd0;
`ifdef ACORN_TAGCHK_EN
      exp_q <= 128'd0;
`endif
    end else if ((state_q == LOAD) && s_xfer_s) begin
      case (fld_s)
        3'(KEY): key_q[lsb_s +: 8] <= s_data;
        3'(IV):  iv_q[lsb_s +: 8]  <= s_data;
        3'(AD):  ad_q[lsb_s +: 8]  <= s_data;
        3'(TXT): txt_q[lsb_s +: 8] <= s_data;
`ifdef ACORN_TAGCHK_EN
        3'd4:    exp_q[lsb_s +: 8] <= s_data;
`endif
        default: ;
      endcase
    end
  end

  acorn128_byte_serializer u_ser (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (cap_s),
    .data_i  (cap_data_s),
    .ready_i (m_ready),
    .data_o  (m_data),
    .valid_o (m_valid_s),
    .last_o  (m_last_s)
  );

  assign s_ready         = srdy_q;
  assign encrypt_out     = enc_q;
  assign start_out       = start_q;
  assign error_out       = err_q;
  assign key_out         = key_q;
  assign iv_out          = iv_q;
  assign ad_out          = ad_q;
  assign text_out        = txt_q;
  assign data_length_out = 64'(DATA_LEN);
  assign m_valid         = m_valid_s;
  assign m_last          = m_last_s;

endmodule
